// File: rtl/apb_cmd_master.sv
// APB initiator that turns single valid/ready commands into APB SETUP/ACCESS transfers
// and returns read data and status on a response channel; includes a pready watchdog.
module apb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_wait;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic            w_expired;

  // w_expired marks the last permitted low-pready ACCESS cycle
  generate
    if (TIMEOUT > 0) begin : g_wd
      assign w_expired = (r_wait == CW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign w_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            if (cmd_write) r_pwdata <= cmd_wdata;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_err   <= pslverr;
            r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_expired) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule
